// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Byte-stream program loader that sits in front of the Harvard processor.
//   A frame is: LEN byte N, then N words of 5 bytes each (MSB first), then one
//   checksum byte (XOR of all word bytes, LEN excluded). Each assembled 37-bit
//   word {opcode[4:0], operand[31:0]} is written to the processor's instruction
//   memory through the wr/address/data_in load port. The processor is held in
//   reset (cpu_hold) from the start of a load until the frame completes cleanly.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid && byte_ready.
//   byte_ready depends only on the state register (never on byte_valid), and it
//   is high only in LEN, DATA and CSUM.
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       begin a load (honoured in IDLE, DONE, ERR only)
//   byte_in     in   8       stream data byte
//   byte_valid  in   1       byte_in is valid
//   byte_ready  out  1       loader accepts a byte this cycle
//   wr          out  1       one-cycle write strobe to the processor
//   address     out  ADDR_W  word index being written
//   data_in     out  WORD_W  assembled word {opcode, operand}
//   cpu_hold    out  1       holds the processor in reset while high
//   done        out  1       load completed with a good checksum
//   err_code    out  2       00 none, 01 bad length, 10 checksum, 11 timeout
//   state_dbg   out  3       current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int MAX_WORDS      = 81,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 7,
  parameter int WORD_W         = 37
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] data_in,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [2:0]        state_dbg
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state;
  logic [2:0]        byte_cnt;   // byte position within the current word
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;   // N-1, latched from the LEN byte
  logic [4:0]        opcode;
  logic [23:0]       operand_sr; // operand bytes 1..3; byte 4 joins at assembly
  logic [7:0]        csum;
  logic [TO_W-1:0]   to_cnt;

  logic xfer;
  logic timeout_hit;

  // Ready and write strobe are pure decodes of the state register.
  assign byte_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign wr          = (state == S_WRITE);
  assign state_dbg   = state;
  assign xfer        = byte_valid && byte_ready;
  // A transfer in the limit cycle wins over the timeout.
  assign timeout_hit = byte_ready && !xfer && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      opcode     <= '0;
      operand_sr <= '0;
      csum       <= '0;
      to_cnt     <= '0;
      address    <= '0;
      data_in    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      // Idle counter: runs only while waiting for bytes, cleared by any transfer.
      if (byte_ready) begin
        if (xfer) to_cnt <= '0;
        else      to_cnt <= to_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state    <= S_ERR;
        err_code <= 2'b11;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state    <= S_LEN;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              err_code <= 2'b00;
              to_cnt   <= '0;
              csum     <= '0;
              byte_cnt <= '0;
              word_idx <= '0;
            end
          end

          S_LEN: begin
            if (xfer) begin
              if (byte_in == 8'd0 || int'(byte_in) > MAX_WORDS) begin
                state    <= S_ERR;
                err_code <= 2'b01;
              end else begin
                last_idx <= ADDR_W'(byte_in - 8'd1);
                word_idx <= '0;
                byte_cnt <= '0;
                state    <= S_DATA;
              end
            end
          end

          S_DATA: begin
            if (xfer) begin
              csum <= csum ^ byte_in;
              if (byte_cnt == 3'd0) opcode <= byte_in[4:0];  // bits [7:5] dropped
              else                  operand_sr <= {operand_sr[15:0], byte_in};
              if (byte_cnt == 3'd4) begin
                // Present address/data together with wr in the next cycle.
                byte_cnt <= '0;
                address  <= word_idx;
                data_in  <= WORD_W'({opcode, operand_sr, byte_in});
                state    <= S_WRITE;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
          end

          S_WRITE: begin
            if (word_idx == last_idx) begin
              state <= S_CSUM;
            end else begin
              word_idx <= word_idx + 1'b1;
              state    <= S_DATA;
            end
          end

          S_CSUM: begin
            if (xfer) begin
              if (byte_in == csum) begin
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= S_ERR;
                err_code <= 2'b10;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
